// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle RV32I main controller:
// state encodings, opcodes, datapath select encodings and ALU codes.
package multicycle_control_unit_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  // Opcodes (IR[6:0])
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Memory address select
  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_RESULT = 1'b1;

  // Result select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Immediate format select
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Operation class handed from the main FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU decoder: maps the FSM's operation class plus instruction function
// fields onto an ALU control code. Purely combinational, reusable standalone.
module alu_decoder
  import multicycle_control_unit_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  // Select ALU operation from the operation class and function fields
  always_comb begin
    // NOTE: a default assigned first on every path keeps this block free of inferred latches.
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type (op[5]=1) with funct7[5] is a subtract; addi ignores it
          3'b000:  alu_control_o = (op5_i & funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style main controller for a multicycle RV32I datapath with a single
// shared memory and a MEM_READY wait-state handshake.
// Optional: define MC_CTRL_ILLEGAL_HALT_EN to halt on unknown opcodes
// (state HALT, HALTED=1, left only by reset); otherwise they act as NOPs.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [6:0]         OPE_CODE,
  input  logic [2:0]         FUNCT3,
  input  logic               FUNCT7_5,
  input  logic               ZERO,
  input  logic               MEM_READY,
  output logic               PC_WRITE,
  output logic               ADR_SRC,
  output logic               MEM_WRITE,
  output logic               IR_WRITE,
  output logic [1:0]         RESULT_SRC,
  output logic [1:0]         ALU_SRC_A,
  output logic [1:0]         ALU_SRC_B,
  output logic [2:0]         ALU_CONTROL,
  output logic [1:0]         IMM_SRC,
  output logic               REG_WRITE,
  output logic [STATE_W-1:0] STATE,
  output logic               HALTED
);

  state_e     state_q, state_d;
  logic       pc_update, branch, ir_write, mem_write, reg_write;
  logic [1:0] alu_op;

  // State register with synchronous reset
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (RST) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = MEM_READY ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (OPE_CODE)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
          default:      state_d = S_HALT;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (OPE_CODE == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = MEM_READY ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = MEM_READY ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
      S_HALT:     state_d = S_HALT;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state datapath selects and raw enables
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    ADR_SRC    = ADR_PC;
    RESULT_SRC = RES_ALUOUT;
    ALU_SRC_A  = SRCA_PC;
    ALU_SRC_B  = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ALU_SRC_B  = SRCB_FOUR;
        RESULT_SRC = RES_ALU;
        ir_write   = MEM_READY;
        pc_update  = MEM_READY;
      end
      S_DECODE: begin
        ALU_SRC_A = SRCA_OLDPC;
        ALU_SRC_B = SRCB_IMM;
      end
      S_MEMADR: begin
        ALU_SRC_A = SRCA_RD1;
        ALU_SRC_B = SRCB_IMM;
      end
      S_MEMREAD: ADR_SRC = ADR_RESULT;
      S_MEMWB: begin
        RESULT_SRC = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ADR_SRC   = ADR_RESULT;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALU_SRC_A = SRCA_RD1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALU_SRC_A = SRCA_RD1;
        ALU_SRC_B = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        ALU_SRC_A = SRCA_RD1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        ALU_SRC_A = SRCA_OLDPC;
        ALU_SRC_B = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (OPE_CODE)
      OP_SW:   IMM_SRC = IMM_S;
      OP_BEQ:  IMM_SRC = IMM_B;
      OP_JAL:  IMM_SRC = IMM_J;
      default: IMM_SRC = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (FUNCT3),
    .funct7_5_i    (FUNCT7_5),
    .op5_i         (OPE_CODE[5]),
    .alu_control_o (ALU_CONTROL)
  );

  // Reset masks every write enable so an abandoned instruction cannot commit
  assign PC_WRITE  = ~RST & (pc_update | (branch & ZERO));
  assign IR_WRITE  = ~RST & ir_write;
  assign MEM_WRITE = ~RST & mem_write;
  assign REG_WRITE = ~RST & reg_write;
  assign STATE     = STATE_W'(state_q);

`ifdef MC_CTRL_ILLEGAL_HALT_EN
  assign HALTED = (state_q == S_HALT);
`else
  assign HALTED = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit. Expectations follow the
// build: define MC_CTRL_ILLEGAL_HALT_EN for both bench and RTL together.
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] OPE_CODE;
  logic [2:0] FUNCT3;
  logic       FUNCT7_5;
  logic       ZERO;
  logic       MEM_READY;
  logic       PC_WRITE, ADR_SRC, MEM_WRITE, IR_WRITE, REG_WRITE, HALTED;
  logic [1:0] RESULT_SRC, ALU_SRC_A, ALU_SRC_B, IMM_SRC;
  logic [2:0] ALU_CONTROL;
  logic [3:0] STATE;

  int checks = 0;
  int errors = 0;

  multicycle_control_unit #(.STATE_W(4)) dut (
    .CLK(CLK), .RST(RST), .OPE_CODE(OPE_CODE), .FUNCT3(FUNCT3),
    .FUNCT7_5(FUNCT7_5), .ZERO(ZERO), .MEM_READY(MEM_READY),
    .PC_WRITE(PC_WRITE), .ADR_SRC(ADR_SRC), .MEM_WRITE(MEM_WRITE),
    .IR_WRITE(IR_WRITE), .RESULT_SRC(RESULT_SRC), .ALU_SRC_A(ALU_SRC_A),
    .ALU_SRC_B(ALU_SRC_B), .ALU_CONTROL(ALU_CONTROL), .IMM_SRC(IMM_SRC),
    .REG_WRITE(REG_WRITE), .STATE(STATE), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then wait for combinational outputs to settle
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RST = 1'b1; OPE_CODE = 7'b0; FUNCT3 = 3'b0; FUNCT7_5 = 1'b0;
    ZERO = 1'b0; MEM_READY = 1'b1;

    // Reset
    tick();
    RST = 1'b0; #1;
    check("reset_state", 8'(STATE), 8'd0);
    check("reset_halted", 8'(HALTED), 8'd0);

    // lw, memory always ready: 0,1,2,3,4,0
    OPE_CODE = 7'b0000011; #1;
    check("lw_fetch_irw", 8'(IR_WRITE), 8'd1);
    check("lw_fetch_pcw", 8'(PC_WRITE), 8'd1);
    check("lw_fetch_srcb", 8'(ALU_SRC_B), 8'd2);
    check("lw_fetch_res", 8'(RESULT_SRC), 8'd2);
    tick();
    check("lw_s1", 8'(STATE), 8'd1);
    check("lw_dec_srca", 8'(ALU_SRC_A), 8'd1);
    check("lw_dec_srcb", 8'(ALU_SRC_B), 8'd1);
    tick();
    check("lw_s2", 8'(STATE), 8'd2);
    check("lw_adr_srca", 8'(ALU_SRC_A), 8'd2);
    check("lw_imm_i", 8'(IMM_SRC), 8'd0);
    tick();
    check("lw_s3", 8'(STATE), 8'd3);
    check("lw_rd_adr", 8'(ADR_SRC), 8'd1);
    check("lw_rd_regw", 8'(REG_WRITE), 8'd0);
    tick();
    check("lw_s4", 8'(STATE), 8'd4);
    check("lw_wb_regw", 8'(REG_WRITE), 8'd1);
    check("lw_wb_res", 8'(RESULT_SRC), 8'd1);
    tick();
    check("lw_s0", 8'(STATE), 8'd0);
    check("lw_end_regw", 8'(REG_WRITE), 8'd0);

    // sw with three wait cycles in MEMWRITE
    OPE_CODE = 7'b0100011;
    tick();
    check("sw_imm_s", 8'(IMM_SRC), 8'd1);
    tick();
    check("sw_s2", 8'(STATE), 8'd2);
    check("sw_s2_memw", 8'(MEM_WRITE), 8'd0);
    tick();
    MEM_READY = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("sw_wait_state", 8'(STATE), 8'd5);
      check("sw_wait_memw", 8'(MEM_WRITE), 8'd1);
      check("sw_wait_adr", 8'(ADR_SRC), 8'd1);
      tick();
    end
    MEM_READY = 1'b1; #1;
    check("sw_last_state", 8'(STATE), 8'd5);
    check("sw_last_memw", 8'(MEM_WRITE), 8'd1);
    tick();
    check("sw_done", 8'(STATE), 8'd0);
    check("sw_done_memw", 8'(MEM_WRITE), 8'd0);

    // Reset while in MEMWRITE with memory ready
    tick(); tick(); tick();
    check("rst_pre_state", 8'(STATE), 8'd5);
    RST = 1'b1; #1;
    check("rst_memw_masked", 8'(MEM_WRITE), 8'd0);
    tick();
    check("rst_mid_state", 8'(STATE), 8'd0);
    check("rst_mid_irw", 8'(IR_WRITE), 8'd0);
    RST = 1'b0; #1;

    // R-type sub
    OPE_CODE = 7'b0110011; FUNCT3 = 3'b000; FUNCT7_5 = 1'b1;
    tick(); tick();
    check("r_s6", 8'(STATE), 8'd6);
    check("r_sub", 8'(ALU_CONTROL), 8'd1);
    check("r_srca", 8'(ALU_SRC_A), 8'd2);
    check("r_srcb", 8'(ALU_SRC_B), 8'd0);
    tick();
    check("r_s8", 8'(STATE), 8'd8);
    check("r_wb_regw", 8'(REG_WRITE), 8'd1);
    check("r_wb_alu_add", 8'(ALU_CONTROL), 8'd0);
    tick();
    check("r_s0", 8'(STATE), 8'd0);

    // addi with FUNCT7_5=1 must still add; also sweep or/slt/and
    OPE_CODE = 7'b0010011;
    tick(); tick();
    check("i_s7", 8'(STATE), 8'd7);
    check("i_addi", 8'(ALU_CONTROL), 8'd0);
    check("i_srcb", 8'(ALU_SRC_B), 8'd1);
    FUNCT3 = 3'b110; #1;
    check("i_ori", 8'(ALU_CONTROL), 8'd3);
    FUNCT3 = 3'b010; #1;
    check("i_slti", 8'(ALU_CONTROL), 8'd5);
    FUNCT3 = 3'b111; #1;
    check("i_andi", 8'(ALU_CONTROL), 8'd2);
    FUNCT3 = 3'b100; #1;
    check("i_other", 8'(ALU_CONTROL), 8'd0);
    tick();
    check("i_s8", 8'(STATE), 8'd8);
    tick();
    FUNCT3 = 3'b000; FUNCT7_5 = 1'b0;

    // beq taken and not taken
    OPE_CODE = 7'b1100011; ZERO = 1'b1;
    tick();
    check("beq_imm_b", 8'(IMM_SRC), 8'd2);
    tick();
    check("beq_s9", 8'(STATE), 8'd9);
    check("beq_taken_pcw", 8'(PC_WRITE), 8'd1);
    check("beq_sub", 8'(ALU_CONTROL), 8'd1);
    ZERO = 1'b0; #1;
    check("beq_nt_pcw", 8'(PC_WRITE), 8'd0);
    tick();
    check("beq_s0", 8'(STATE), 8'd0);

    // FETCH stalled on memory
    MEM_READY = 1'b0; #1;
    check("stall_irw", 8'(IR_WRITE), 8'd0);
    check("stall_pcw", 8'(PC_WRITE), 8'd0);
    tick();
    check("stall_state", 8'(STATE), 8'd0);
    MEM_READY = 1'b1; #1;

    // jal
    OPE_CODE = 7'b1101111;
    tick();
    check("jal_imm_j", 8'(IMM_SRC), 8'd3);
    tick();
    check("jal_s10", 8'(STATE), 8'd10);
    check("jal_pcw", 8'(PC_WRITE), 8'd1);
    check("jal_srca", 8'(ALU_SRC_A), 8'd1);
    check("jal_srcb", 8'(ALU_SRC_B), 8'd2);
    tick();
    check("jal_s8", 8'(STATE), 8'd8);
    tick();
    check("jal_s0", 8'(STATE), 8'd0);

    // Illegal opcode
    OPE_CODE = 7'b1111111;
    tick();
    check("ill_s1", 8'(STATE), 8'd1);
    tick();
`ifdef MC_CTRL_ILLEGAL_HALT_EN
    for (int i = 0; i < 10; i++) begin
      check("ill_halt_state", 8'(STATE), 8'd11);
      check("ill_halted", 8'(HALTED), 8'd1);
      check("ill_halt_pcw", 8'(PC_WRITE), 8'd0);
      tick();
    end
    RST = 1'b1;
    tick();
    RST = 1'b0; #1;
    check("ill_rst_state", 8'(STATE), 8'd0);
    check("ill_rst_halted", 8'(HALTED), 8'd0);
`else
    check("ill_nop_state", 8'(STATE), 8'd0);
    check("ill_nop_halted", 8'(HALTED), 8'd0);
    tick();
    check("ill_nop_next", 8'(STATE), 8'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
